content_ram_loader: RTL

- Writer side of the content memory that the MD5 controller reads, one 256-bit word per address.
- Accepts a byte stream of LED frame content over a valid/ready handshake.
- Packs 32 bytes into one 256-bit word in MD5 little-endian byte order, so the first byte lands in word bits [7:0].
- Writes words to sequential addresses 0..DEPTH-1 and flags frame completion so hashing can start.

---
 rtl/content_ram_loader_pkg.sv | 19 +
 rtl/content_ram_loader_if.sv | 27 ++
 rtl/content_ram_loader_byte_packer.sv | 45 ++++
 rtl/content_ram_loader.sv | 112 +++++++++++
 4 files changed

// File: rtl/content_ram_loader_pkg.sv
// Shared widths and state encoding for the content RAM writer and the MD5 reader.
// Both sides import this so word width and address width agree by construction.
package content_ram_loader_pkg;

  localparam int ADDR_W     = 10;
  localparam int DEPTH      = 2 ** ADDR_W;
  localparam int WORD_BYTES = 32;
  localparam int WORD_W     = 8 * WORD_BYTES;
  localparam int IDX_W      = $clog2(WORD_BYTES);

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_FILL = 3'b010,
    ST_DONE = 3'b100
  } state_e;

endpackage

// File: rtl/content_ram_loader_if.sv
// Byte-stream input, memory write port and frame status of the content RAM loader.
// master = stream source / environment, slave = the loader itself.
interface content_ram_loader_if;
  import content_ram_loader_pkg::*;

  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_last;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  word_t             wr_data;
  logic [ADDR_W:0]   word_count;
  logic              frame_done;

  modport master (
    output start, in_valid, in_data, in_last,
    input  in_ready, wr_en, wr_addr, wr_data, word_count, frame_done
  );

  modport slave (
    input  start, in_valid, in_data, in_last,
    output in_ready, wr_en, wr_addr, wr_data, word_count, frame_done
  );

endinterface

// File: rtl/content_ram_loader_byte_packer.sv
// Packs accepted bytes little-endian into a 256-bit word; close fires combinationally
// on byte 31 or on a last byte, with word_o carrying the zero-padded result that cycle.
module content_ram_loader_byte_packer
  import content_ram_loader_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       clear,
  input  logic       accept,
  input  logic [7:0] byte_in,
  input  logic       last_in,
  output logic       close,
  output word_t      word_o
);

  logic [IDX_W-1:0] idx_q, idx_d;
  word_t            pack_q, pack_d;

  always_comb begin
    word_o                  = pack_q;
    word_o[8*idx_q +: 8]    = byte_in;
    close                   = accept && (last_in || idx_q == IDX_W'(WORD_BYTES - 1));
    idx_d                   = idx_q;
    pack_d                  = pack_q;
    // Buffer returns to zero after every close, which is what zero-pads short words.
    if (clear || close) begin
      idx_d  = '0;
      pack_d = '0;
    end else if (accept) begin
      idx_d  = idx_q + 1'b1;
      pack_d = word_o;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      idx_q  <= '0;
      pack_q <= '0;
    end else begin
      idx_q  <= idx_d;
      pack_q <= pack_d;
    end
  end

endmodule

// File: rtl/content_ram_loader.sv
// Loads a byte stream into sequential 256-bit content RAM words and flags frame end.
// Never stalls in FILL; closing byte at t -> wr_en at t+1 -> frame_done at t+2.
module content_ram_loader
  import content_ram_loader_pkg::*;
(
  input  logic                Clk,
  input  logic                Reset,
  content_ram_loader_if.slave bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;
  word_t             wr_data_q, wr_data_d;
  logic              wr_en_q, wr_en_d;
  logic              end_pend_q, end_pend_d;

  logic              in_ready;
  logic              frame_done;
  logic              accept;
  logic              restart;
  logic              close;
  word_t             close_word;
  logic [ADDR_W-1:0] close_addr;

  content_ram_loader_byte_packer u_packer (
    .Clk     (Clk),
    .Reset   (Reset),
    .clear   (restart),
    .accept  (accept),
    .byte_in (bus.in_data),
    .last_in (bus.in_last),
    .close   (close),
    .word_o  (close_word)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_FILL;
      ST_FILL: if (wr_en_q && end_pend_q) state_d = ST_DONE;
      ST_DONE: if (bus.start) state_d = ST_FILL;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state_q == ST_FILL) && !end_pend_q;
    frame_done = (state_q == ST_DONE);
  end

  always_comb begin
    restart    = bus.start && (state_q == ST_IDLE || state_q == ST_DONE);
    accept     = bus.in_valid && in_ready;
    // A word closing during a write strobe belongs to the address after the one being written.
    close_addr = wr_en_q ? wr_addr_q + 1'b1 : wr_addr_q;

    wr_en_d    = close;
    wr_data_d  = close ? close_word : wr_data_q;

    end_pend_d = end_pend_q;
    if (close) begin
      end_pend_d = bus.in_last || (close_addr == ADDR_W'(DEPTH - 1));
    end else if (wr_en_q) begin
      end_pend_d = 1'b0;
    end

    wr_addr_d    = wr_addr_q;
    word_count_d = word_count_q;
    if (restart) begin
      wr_addr_d    = '0;
      word_count_d = '0;
    end else if (wr_en_q) begin
      word_count_d = word_count_q + 1'b1;
      if (wr_addr_q != ADDR_W'(DEPTH - 1)) begin
        wr_addr_d = wr_addr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_addr_q    <= '0;
      word_count_q <= '0;
      wr_data_q    <= '0;
      wr_en_q      <= 1'b0;
      end_pend_q   <= 1'b0;
    end else begin
      wr_addr_q    <= wr_addr_d;
      word_count_q <= word_count_d;
      wr_data_q    <= wr_data_d;
      wr_en_q      <= wr_en_d;
      end_pend_q   <= end_pend_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.word_count = word_count_q;
  assign bus.frame_done = frame_done;

endmodule
